// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction-fetch stage.
package fetch_pkg;

   localparam int XLEN_DEF      = 32;
   localparam int PC_INC        = 4;
   localparam int PC_BRANCH_OFF = 8;

   typedef enum logic {
      FETCH = 1'b0,
      FLUSH = 1'b1
   } fetch_state_t;

endpackage

// File: rtl/fetch_unit_branch_target_calc.sv
// Combinational PC+8 and word-aligned branch target (PC + 8 + ExtImm).
// Zero latency, no flow control.
module branch_target_calc
   import fetch_pkg::*;
#(
   parameter int XLEN = XLEN_DEF
) (
   input  logic [XLEN-1:0] pc,
   input  logic [XLEN-1:0] ext_imm,
   output logic [XLEN-1:0] pc_plus8,
   output logic [XLEN-1:0] target
);

   localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(3));

   logic [XLEN-1:0] raw_target;

   always_comb begin
      pc_plus8   = pc + XLEN'(PC_BRANCH_OFF);
      raw_target = pc_plus8 + ext_imm;
      target     = raw_target & ALIGN_MASK;
   end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: one instruction per cycle when unstalled; a taken branch costs two bubbles.
// Downstream stall holds the current instruction and suppresses new memory requests.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int              XLEN     = XLEN_DEF,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            reset,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ready,
   input  logic [XLEN-1:0] imem_rdata,
   input  logic            stall,
   input  logic            branch_taken,
   input  logic [XLEN-1:0] ExtImm,
   output logic [XLEN-1:0] Instr,
   output logic            instr_valid,
   output logic [XLEN-1:0] PC,
   output logic [XLEN-1:0] PCPlus8
);

   fetch_state_t    state_q, state_d;
   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   logic [XLEN-1:0] instr_q, instr_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic            instr_valid_q, instr_valid_d;

   logic            slot_free;
   logic            capture;
   logic            redirect;
   logic [XLEN-1:0] branch_target;

   branch_target_calc #(.XLEN(XLEN)) u_btc (
      .pc       (pc_q),
      .ext_imm  (ExtImm),
      .pc_plus8 (PCPlus8),
      .target   (branch_target)
   );

   always_comb begin
      slot_free = !instr_valid_q || !stall;
      imem_req  = (state_q == FETCH) && slot_free && !reset;
      imem_addr = fetch_pc_q;
      capture   = imem_req && imem_ready;
      redirect  = branch_taken && instr_valid_q;

      state_d       = state_q;
      fetch_pc_d    = fetch_pc_q;
      instr_d       = instr_q;
      pc_d          = pc_q;
      instr_valid_d = instr_valid_q;

      // Branch wins over stall and capture; any same-cycle memory data is dropped.
      if (redirect) begin
         fetch_pc_d    = branch_target;
         instr_valid_d = 1'b0;
         state_d       = FLUSH;
      end else if (state_q == FLUSH) begin
         state_d = FETCH;
      end else if (capture) begin
         instr_d       = imem_rdata;
         pc_d          = fetch_pc_q;
         instr_valid_d = 1'b1;
         fetch_pc_d    = fetch_pc_q + XLEN'(PC_INC);
      end else if (instr_valid_q && !stall) begin
         instr_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= FETCH;
         fetch_pc_q    <= RESET_PC;
         instr_q       <= '0;
         pc_q          <= '0;
         instr_valid_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         fetch_pc_q    <= fetch_pc_d;
         instr_q       <= instr_d;
         pc_q          <= pc_d;
         instr_valid_q <= instr_valid_d;
      end
   end

   assign Instr       = instr_q;
   assign PC          = pc_q;
   assign instr_valid = instr_valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential fetch, stall, branches, memory wait, reset, wrap.
module tb_fetch_unit;

   localparam logic [31:0] TAG_XOR = 32'hE0000000;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_ready;
   logic        stall;
   logic        branch_taken;
   logic [31:0] ext_imm;

   logic        req0, valid0;
   logic [31:0] addr0, rdata0, instr0, pc0, pc8_0;
   logic        req1, valid1;
   logic [31:0] addr1, rdata1, instr1, pc1, pc8_1;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   assign rdata0 = addr0 ^ TAG_XOR;
   assign rdata1 = addr1 ^ TAG_XOR;

   fetch_unit #(.XLEN(32), .RESET_PC(32'h00000000)) dut (
      .clk          (clk),
      .reset        (reset),
      .imem_req     (req0),
      .imem_addr    (addr0),
      .imem_ready   (imem_ready),
      .imem_rdata   (rdata0),
      .stall        (stall),
      .branch_taken (branch_taken),
      .ExtImm       (ext_imm),
      .Instr        (instr0),
      .instr_valid  (valid0),
      .PC           (pc0),
      .PCPlus8      (pc8_0)
   );

   fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFFFFFC)) dut_wrap (
      .clk          (clk),
      .reset        (reset),
      .imem_req     (req1),
      .imem_addr    (addr1),
      .imem_ready   (imem_ready),
      .imem_rdata   (rdata1),
      .stall        (stall),
      .branch_taken (branch_taken),
      .ExtImm       (ext_imm),
      .Instr        (instr1),
      .instr_valid  (valid1),
      .PC           (pc1),
      .PCPlus8      (pc8_1)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_instr(input string tag, input logic [31:0] pc_exp);
      check_eq({tag, "_valid"}, 32'(valid0), 32'd1);
      check_eq({tag, "_pc"}, pc0, pc_exp);
      check_eq({tag, "_instr"}, instr0, pc_exp ^ TAG_XOR);
   endtask

   initial begin
      reset        = 1'b1;
      imem_ready   = 1'b1;
      stall        = 1'b0;
      branch_taken = 1'b0;
      ext_imm      = '0;
      tick();
      tick();

      // Reset state
      check_eq("rst_valid", 32'(valid0), 32'd0);
      check_eq("rst_pc", pc0, 32'h0);
      check_eq("rst_instr", instr0, 32'h0);
      check_eq("rst_req", 32'(req0), 32'd0);
      check_eq("rst_addr", addr0, 32'h0);

      // Sequential fetch
      reset = 1'b0;
      #1;
      check_eq("seq_req", 32'(req0), 32'd1);
      tick();
      expect_instr("seq0", 32'h0);
      tick();
      expect_instr("seq4", 32'h4);
      tick();
      expect_instr("seq8", 32'h8);

      // Stall holds PC=8 for three cycles
      stall = 1'b1;
      #1;
      check_eq("stall_req", 32'(req0), 32'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         expect_instr("stall_hold", 32'h8);
         check_eq("stall_req_hold", 32'(req0), 32'd0);
      end
      stall = 1'b0;
      tick();
      expect_instr("stall_rel", 32'hC);
      tick();
      expect_instr("pre_br", 32'h10);

      // Forward branch from 0x10 with ExtImm=0x20 -> 0x38
      check_eq("pc_plus8", pc8_0, 32'h18);
      ext_imm      = 32'h20;
      branch_taken = 1'b1;
      tick();
      branch_taken = 1'b0;
      #1;
      check_eq("fwd_flush_valid", 32'(valid0), 32'd0);
      check_eq("fwd_flush_req", 32'(req0), 32'd0);
      check_eq("fwd_flush_addr", addr0, 32'h38);
      tick();
      check_eq("fwd_fetch_valid", 32'(valid0), 32'd0);
      check_eq("fwd_fetch_req", 32'(req0), 32'd1);
      check_eq("fwd_fetch_addr", addr0, 32'h38);
      tick();
      expect_instr("fwd_tgt", 32'h38);
      tick();
      expect_instr("fwd_next", 32'h3C);
      tick();
      expect_instr("pre_bwd", 32'h40);

      // Backward branch 0x40 + 8 - 0x18 = 0x30, taken despite stall
      ext_imm      = 32'hFFFFFFE8;
      stall        = 1'b1;
      branch_taken = 1'b1;
      tick();
      stall = 1'b0;
      check_eq("bwd_flush_valid", 32'(valid0), 32'd0);
      check_eq("bwd_flush_addr", addr0, 32'h30);
      tick();
      // branch_taken still high with no valid instruction: no redirect
      check_eq("ign_addr_fetch", addr0, 32'h30);
      tick();
      branch_taken = 1'b0;
      expect_instr("bwd_tgt", 32'h30);
      check_eq("ign_addr_next", addr0, 32'h34);

      // Memory wait at 0x34
      imem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_eq("wait_valid", 32'(valid0), 32'd0);
         check_eq("wait_addr", addr0, 32'h34);
         check_eq("wait_req", 32'(req0), 32'd1);
      end
      imem_ready = 1'b1;
      tick();
      expect_instr("wait_done", 32'h34);

      // Reset asserted mid-wait
      imem_ready = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      check_eq("midrst_valid", 32'(valid0), 32'd0);
      check_eq("midrst_addr", addr0, 32'h0);
      check_eq("midrst_pc", pc0, 32'h0);
      check_eq("wrap_rst_addr", addr1, 32'hFFFFFFFC);

      // Wrap-around on the high-reset instance
      reset      = 1'b0;
      imem_ready = 1'b1;
      tick();
      check_eq("wrap_pc0", pc1, 32'hFFFFFFFC);
      check_eq("wrap_instr0", instr1, 32'h1FFFFFFC);
      check_eq("wrap_valid0", 32'(valid1), 32'd1);
      expect_instr("rerun0", 32'h0);
      tick();
      check_eq("wrap_pc1", pc1, 32'h0);
      check_eq("wrap_instr1", instr1, 32'hE0000000);
      tick();
      check_eq("wrap_pc2", pc1, 32'h4);
      expect_instr("rerun8", 32'h8);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
